lcd_value_render: RTL and testbench

Pixel-generation stage placed directly downstream of the LCD timing generator on the 480x272 panel path. It consumes the generator's data-enable, sync and pixel-address outputs. It produces RGB565 pixel data showing a 9-character measured-value string, such as "0012.34" with a unit glyph, in a fixed text box over a solid background. New values arrive through a valid/ready handshake and are committed only at a frame boundary, so a frame never shows a partly updated value.

---
 rtl/lcd_value_render_if.sv | 10 +
 rtl/lcd_value_render.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_value_render.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_value_render_if.sv
// Value handshake into lcd_value_render: a 36-bit nine-character string
// offered with valid/ready.
interface lcd_value_render_if;
    logic [35:0] val_data;
    logic        val_valid;
    logic        val_ready;

    modport master (output val_data, output val_valid, input val_ready);
    modport slave  (input val_data, input val_valid, output val_ready);
endinterface

// File: rtl/lcd_value_render.sv
// Renders a nine-character value string in a 72x16 text box over a solid
// background, three clocks behind the LCD timing generator.
module lcd_value_render #(
    parameter int          X0       = 16,
    parameter int          Y0       = 100,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h001F
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                de_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [10:0]         col_in,
    input  logic [10:0]         row_in,
    lcd_value_render_if.slave   val_if,
    output logic [15:0]         lcd_rgb,
    output logic                lcd_de,
    output logic                lcd_hsync,
    output logic                lcd_vsync
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 72);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + 16);
    localparam logic [35:0] RESET_STR = 36'hF_EEEE_EEEE;

    // ---------------- value path ----------------
    logic [35:0] r_pend;
    logic [35:0] r_disp;
    logic        r_pend_full;
    logic        r_val_ready;
    logic        r_vsync_q;
    logic        w_fire;
    logic        w_boundary;
    logic        w_pend_full_next;

    assign w_fire          = val_if.val_valid & r_val_ready;
    assign w_boundary      = r_vsync_q & ~vsync_in;
    assign val_if.val_ready = r_val_ready;

    // A fire in the boundary cycle only fills pend; commit needs pend already full.
    always_comb begin
        w_pend_full_next = r_pend_full;
        if (w_boundary && r_pend_full)
            w_pend_full_next = 1'b0;
        if (w_fire)
            w_pend_full_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend      <= '0;
            r_disp      <= RESET_STR;
            r_pend_full <= 1'b0;
            r_val_ready <= 1'b1;
            r_vsync_q   <= 1'b1;
        end else begin
            r_vsync_q   <= vsync_in;
            r_pend_full <= w_pend_full_next;
            r_val_ready <= ~w_pend_full_next;
            if (w_fire)
                r_pend <= val_if.val_data;
            if (w_boundary && r_pend_full)
                r_disp <= r_pend;
        end
    end

    // ---------------- stage 1: box decode ----------------
    logic       w_col_ge;
    logic       w_row_ge;
    logic       w_in_box;
    logic [6:0] w_dx;
    logic [3:0] w_dy;

    // A zero origin makes the lower-bound compare trivially true.
    if (X0 == 0) begin : g_col_zero
        assign w_col_ge = 1'b1;
    end else begin : g_col_cmp
        assign w_col_ge = (col_in >= X_LO);
    end
    if (Y0 == 0) begin : g_row_zero
        assign w_row_ge = 1'b1;
    end else begin : g_row_cmp
        assign w_row_ge = (row_in >= Y_LO);
    end

    assign w_in_box = w_col_ge && (col_in < X_HI) && w_row_ge && (row_in < Y_HI);
    assign w_dx     = col_in[6:0] - X_LO[6:0];
    assign w_dy     = row_in[3:0] - Y_LO[3:0];

    logic       r_s1_de, r_s1_hs, r_s1_vs, r_s1_in_box;
    logic [3:0] r_s1_char;
    logic [3:0] r_s1_grow;
    logic [2:0] r_s1_bit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_s1_in_box <= 1'b0;
            r_s1_char   <= '0;
            r_s1_grow   <= '0;
            r_s1_bit    <= '0;
        end else begin
            r_s1_de     <= de_in;
            r_s1_hs     <= hsync_in;
            r_s1_vs     <= vsync_in;
            r_s1_in_box <= de_in & w_in_box;
            r_s1_char   <= w_dx[6:3];
            r_s1_grow   <= w_dy;
            r_s1_bit    <= w_dx[2:0];
        end
    end

    // ---------------- stage 2: glyph fetch ----------------
    logic [3:0] w_chars [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_chars
        if (gi < 9) begin : g_used
            assign w_chars[gi] = r_disp[gi*4 +: 4];
        end else begin : g_pad
            assign w_chars[gi] = 4'hF;
        end
    end

    // Glyph rows are packed row 0 in the top byte.
    function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
        logic [127:0] g;
        case (code)
            4'd0:    g = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            4'd1:    g = 128'h00001838781818181818187E00000000;
            4'd2:    g = 128'h00007CC6060C183060C0C6FE00000000;
            4'd3:    g = 128'h00007CC606063C060606C67C00000000;
            4'd4:    g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    g = 128'h0000FEC0C0C0FC060606C67C00000000;
            4'd6:    g = 128'h00003860C0C0FCC6C6C6C67C00000000;
            4'd7:    g = 128'h0000FEC606060C183030303000000000;
            4'd8:    g = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            4'd9:    g = 128'h00007CC6C6C67E0606060C7800000000;
            4'd10:   g = 128'h00000000000000000000181800000000;
            4'd11:   g = 128'h0000FE6662687868606060F000000000;
            4'd12:   g = 128'h0000C6C6C6C6FEC6C6C6C6C600000000;
            4'd13:   g = 128'h0000386CC6C6C66C6C6C6CEE00000000;
            4'd14:   g = 128'h000000000000007E7E00000000000000;
            default: g = '0;
        endcase
        return g[{~row, 3'b000} +: 8];
    endfunction

    logic [7:0] w_glyph_row;
    logic       w_lit;

    assign w_glyph_row = font_row(w_chars[r_s1_char], r_s1_grow);
    assign w_lit       = r_s1_in_box & w_glyph_row[~r_s1_bit];

    logic r_s2_de, r_s2_hs, r_s2_vs, r_s2_lit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_de  <= 1'b0;
            r_s2_hs  <= 1'b1;
            r_s2_vs  <= 1'b1;
            r_s2_lit <= 1'b0;
        end else begin
            r_s2_de  <= r_s1_de;
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_s2_lit <= w_lit;
        end
    end

    // ---------------- stage 3: colour ----------------
    logic [15:0] r_rgb;
    logic        r_de, r_hs, r_vs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rgb <= '0;
            r_de  <= 1'b0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_de  <= r_s2_de;
            r_hs  <= r_s2_hs;
            r_vs  <= r_s2_vs;
            if (!r_s2_de)
                r_rgb <= 16'h0000;
            else if (r_s2_lit)
                r_rgb <= FG_COLOR;
            else
                r_rgb <= BG_COLOR;
        end
    end

    assign lcd_rgb   = r_rgb;
    assign lcd_de    = r_de;
    assign lcd_hsync = r_hs;
    assign lcd_vsync = r_vs;

endmodule

// File: tb/tb_lcd_value_render.sv
// Bench for lcd_value_render: scaled-down frames drive two instances (box at
// 16,100 and at 0,0) and every output is compared with a pixel-rule model.
module tb_lcd_value_render;

    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h001F;
    localparam logic [35:0] RST_STR = 36'hF_EEEE_EEEE;
    localparam logic [35:0] VAL_123 = 36'hD_3210_0000;
    localparam int H_ACT = 101, H_TOT = 110;
    localparam int V_ACT = 41,  V_TOT = 45;
    localparam int XA = 16, YA = 100;

    localparam logic [127:0] FONT [16] = '{
        128'h00007CC6C6CEDEF6E6C6C67C00000000, 128'h00001838781818181818187E00000000,
        128'h00007CC6060C183060C0C6FE00000000, 128'h00007CC606063C060606C67C00000000,
        128'h00000C1C3C6CCCFE0C0C0C1E00000000, 128'h0000FEC0C0C0FC060606C67C00000000,
        128'h00003860C0C0FCC6C6C6C67C00000000, 128'h0000FEC606060C183030303000000000,
        128'h00007CC6C6C67CC6C6C6C67C00000000, 128'h00007CC6C6C67E0606060C7800000000,
        128'h00000000000000000000181800000000, 128'h0000FE6662687868606060F000000000,
        128'h0000C6C6C6C6FEC6C6C6C6C600000000, 128'h0000386CC6C6C66C6C6C6CEE00000000,
        128'h000000000000007E7E00000000000000, 128'h00000000000000000000000000000000
    };

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tb_de = 1'b0, tb_hs = 1'b1, tb_vs = 1'b1;
    logic [10:0] tb_col = '0, tb_row = '0;
    logic [35:0] tb_vd = '0;
    logic        tb_vv = 1'b0;

    logic [15:0] rgb1, rgb0;
    logic        de1, hs1, vs1, de0, hs0, vs0;

    always #5 clk = ~clk;

    lcd_value_render_if vif1 ();
    lcd_value_render_if vif0 ();
    assign vif1.val_data  = tb_vd;
    assign vif1.val_valid = tb_vv;
    assign vif0.val_data  = tb_vd;
    assign vif0.val_valid = tb_vv;

    lcd_value_render #(.X0(XA), .Y0(YA), .FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clk(clk), .rstn(rstn), .de_in(tb_de), .hsync_in(tb_hs), .vsync_in(tb_vs),
        .col_in(tb_col), .row_in(tb_row), .val_if(vif1),
        .lcd_rgb(rgb1), .lcd_de(de1), .lcd_hsync(hs1), .lcd_vsync(vs1));

    lcd_value_render #(.X0(0), .Y0(0), .FG_COLOR(FG), .BG_COLOR(BG)) dut0 (
        .clk(clk), .rstn(rstn), .de_in(tb_de), .hsync_in(tb_hs), .vsync_in(tb_vs),
        .col_in(tb_col), .row_in(tb_row), .val_if(vif0),
        .lcd_rgb(rgb0), .lcd_de(de0), .lcd_hsync(hs0), .lcd_vsync(vs0));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected colour of one pixel straight from the drawing rules.
    function automatic logic [15:0] pix(input logic de, input logic [10:0] c, input logic [10:0] r,
                                        input logic [35:0] disp, input int x0, input int y0);
        int col, row, ch, px, gr;
        logic [3:0]   code;
        logic [127:0] g;
        logic [7:0]   line;
        col = int'(c);
        row = int'(r);
        if (!de) return 16'h0000;
        if (col < x0 || col >= x0 + 72 || row < y0 || row >= y0 + 16) return BG;
        ch   = (col - x0) / 8;
        px   = (col - x0) % 8;
        gr   = row - y0;
        code = disp[ch*4 +: 4];
        g    = FONT[code];
        line = g[(15 - gr)*8 +: 8];
        return line[7 - px] ? FG : BG;
    endfunction

    typedef struct {
        logic        de, hs, vs;
        logic [10:0] col, row;
        logic [35:0] disp;
        logic [15:0] rgb1, rgb0;
    } ent_t;

    ent_t        pipe [3];
    ent_t        rst_ent;
    logic [35:0] m_pend, m_disp;
    logic        m_pend_full, m_prev_vs, m_last_fire;
    bit          started = 0;

    initial begin
        rst_ent = '{de: 1'b0, hs: 1'b1, vs: 1'b1, col: '0, row: '0, disp: RST_STR, rgb1: '0, rgb0: '0};
        for (int i = 0; i < 3; i++) pipe[i] = rst_ent;
        m_pend = '0; m_disp = RST_STR; m_pend_full = 1'b0; m_prev_vs = 1'b1; m_last_fire = 1'b0;
    end

    // Reference model: value registers plus a three-clock output delay.
    always @(posedge clk) begin
        started = 1;
        if (!rstn) begin
            m_pend = '0; m_disp = RST_STR; m_pend_full = 1'b0; m_prev_vs = 1'b1; m_last_fire = 1'b0;
            for (int i = 0; i < 3; i++) pipe[i] = rst_ent;
        end else begin
            ent_t e;
            logic fire, bnd;
            fire = tb_vv && !m_pend_full;
            bnd  = m_prev_vs && !tb_vs;
            if (bnd && m_pend_full) begin m_disp = m_pend; m_pend_full = 1'b0; end
            if (fire) begin m_pend = tb_vd; m_pend_full = 1'b1; end
            m_prev_vs   = tb_vs;
            m_last_fire = fire;
            e.de = tb_de; e.hs = tb_hs; e.vs = tb_vs; e.col = tb_col; e.row = tb_row; e.disp = m_disp;
            e.rgb1 = pix(tb_de, tb_col, tb_row, m_disp, XA, YA);
            e.rgb0 = pix(tb_de, tb_col, tb_row, m_disp, 0, 0);
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            ent_t e;
            logic exp_rdy;
            e       = rstn ? pipe[2] : rst_ent;
            exp_rdy = rstn ? !m_pend_full : 1'b1;
            check("rgb",       rgb1, e.rgb1);
            check("rgb_x0",    rgb0, e.rgb0);
            check("de",        de1,  e.de);
            check("hsync",     hs1,  e.hs);
            check("vsync",     vs1,  e.vs);
            check("de_x0",     de0,  e.de);
            check("hsync_x0",  hs0,  e.hs);
            check("vsync_x0",  vs0,  e.vs);
            check("ready",     vif1.val_ready, exp_rdy);
            check("ready_x0",  vif0.val_ready, exp_rdy);
            if (rstn && e.de) begin
                if (e.disp == RST_STR && e.row == 11'(YA+7) && e.col == 11'(XA+1))  check("pin_dash_lit",  rgb1, 16'hFFFF);
                if (e.disp == RST_STR && e.row == 11'(YA+8) && e.col == 11'(XA+71)) check("pin_blank",     rgb1, 16'h001F);
                if (e.disp == VAL_123 && e.row == 11'(YA+2) && e.col == 11'(XA+43)) check("pin_one_lit",   rgb1, 16'hFFFF);
                if (e.disp == VAL_123 && e.row == 11'(YA+2) && e.col == 11'(XA+45)) check("pin_one_unlit", rgb1, 16'h001F);
                if (e.disp == VAL_123 && e.row == 11'(YA+2) && e.col == 11'(XA+66)) check("pin_ohm_lit",   rgb1, 16'hFFFF);
                if (e.col == 11'd2047 && e.row == 11'd7) check("pin_wrap_col", rgb0, 16'h001F);
                if (e.row == 11'd2047 && e.col == 11'd1) check("pin_wrap_row", rgb0, 16'h001F);
            end
        end
    end

    logic [35:0] offer_q [$];

    function automatic logic [10:0] col_of(input int h);
        if (h == 0) return 11'd2047;
        return 11'(h - 1);
    endfunction

    function automatic logic [10:0] row_of(input int r);
        if (r == 0)  return 11'd2047;
        if (r <= 16) return 11'(r - 1);
        return 11'(96 + r - 17);
    endfunction

    function automatic logic [35:0] rand36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic set_inputs(input int v, input int h);
        tb_de  = (v < V_ACT) && (h < H_ACT);
        tb_col = tb_de ? col_of(h) : 11'($urandom_range(0, 2047));
        tb_row = tb_de ? row_of(v) : 11'($urandom_range(0, 2047));
        tb_hs  = !(h >= 103 && h < 107);
        tb_vs  = !(v == 42 || v == 43);
        tb_vv  = (offer_q.size() > 0);
        tb_vd  = tb_vv ? offer_q[0] : rand36();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int v = 0; v < V_TOT; v++) begin
                for (int h = 0; h < H_TOT; h++) begin
                    @(posedge clk);
                    #2;
                    if (m_last_fire && offer_q.size() > 0) void'(offer_q.pop_front());
                    if (f == 0 && v == 10 && h == 20) offer_q.push_back(VAL_123);
                    if (f == 0 && v == 10 && h == 21) check("accept_drops_ready", vif1.val_ready, 1'b0);
                    if (f == 0 && v == 42 && h == 0)  check("ready_low_before_commit", vif1.val_ready, 1'b0);
                    if (f == 0 && v == 42 && h == 1)  check("ready_after_commit", vif1.val_ready, 1'b1);
                    if (f == 1 && v == 5 && h == 0) begin
                        offer_q.push_back(rand36());
                        offer_q.push_back(rand36());
                    end
                    if (f == 1 && v == 20 && h == 0) check("b_held", vif1.val_ready, 1'b0);
                    if (f == 1 && v == 42 && h == 1) check("b_ready_after_commit", vif1.val_ready, 1'b1);
                    if (f == 1 && v == 42 && h == 2) check("b_accepted", vif1.val_ready, 1'b0);
                    if (f == 4 && v == 42 && h == 0) offer_q.push_back(rand36());
                    if (f == 4 && v == 42 && h == 1) check("edge_fire_pending", vif1.val_ready, 1'b0);
                    if ((f == 6 || f == 7) && offer_q.size() == 0 && $urandom_range(0, 199) == 0)
                        offer_q.push_back(rand36());
                    if (f == 8 && v == 10 && h == 0) offer_q.push_back(rand36());
                    if (f == 8 && v == 20 && h == 50) begin
                        rstn = 1'b0;
                        offer_q.delete();
                    end
                    if (f == 8 && v == 20 && h == 51) begin
                        check("reset_rgb", rgb1, 16'h0000);
                        check("reset_hsync", hs1, 1'b1);
                        check("reset_ready", vif1.val_ready, 1'b1);
                    end
                    if (f == 8 && v == 20 && h == 52) rstn = 1'b1;
                    set_inputs(v, h);
                end
            end
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
